// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates slots at issue, collects ALU/LSB
// results, retires one ready head entry per cycle and flushes on branch mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_POS_W = 4,
    parameter int REG_POS_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic                 rob_full,
    input  logic                 issue,
    output logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic [REG_POS_W-1:0] issue_rd,
    input  logic                 issue_ready,
    input  logic [DATA_W-1:0]    issue_val,
    input  logic                 issue_is_br,
    input  logic                 issue_is_store,
    input  logic                 issue_pred_jmp,
    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [DATA_W-1:0]    alu_val,
    input  logic                 alu_jmp,
    input  logic [DATA_W-1:0]    alu_pc,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos,
    input  logic [DATA_W-1:0]    lsb_val,
    input  logic [ROB_POS_W-1:0] q1_pos,
    input  logic [ROB_POS_W-1:0] q2_pos,
    output logic                 q1_ready,
    output logic                 q2_ready,
    output logic [DATA_W-1:0]    q1_val,
    output logic [DATA_W-1:0]    q2_val,
    output logic                 commit,
    output logic [REG_POS_W-1:0] commit_rd,
    output logic [DATA_W-1:0]    commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 commit_store,
    output logic                 rollback,
    output logic [DATA_W-1:0]    rollback_pc
);

    logic                 busy_q    [ROB_SIZE];
    logic                 ready_q   [ROB_SIZE];
    logic [REG_POS_W-1:0] rd_q      [ROB_SIZE];
    logic [DATA_W-1:0]    val_q     [ROB_SIZE];
    logic                 isBr_q    [ROB_SIZE];
    logic                 isStore_q [ROB_SIZE];
    logic                 predJmp_q [ROB_SIZE];
    logic                 jmp_q     [ROB_SIZE];
    logic [DATA_W-1:0]    pc_q      [ROB_SIZE];

    logic [ROB_POS_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_POS_W:0]   count_q, count_d;

    logic                 commit_q, commitStore_q, rollback_q;
    logic [REG_POS_W-1:0] commitRd_q;
    logic [DATA_W-1:0]    commitVal_q, rollbackPc_q;
    logic [ROB_POS_W-1:0] commitPos_q;

    logic retireOk, mispredict, issueOk, lsbWrite;

    assign rob_full       = (count_q == (ROB_POS_W+1)'(ROB_SIZE));
    assign issue_rob_pos  = tail_q;
    assign commit         = commit_q;
    assign commit_rd      = commitRd_q;
    assign commit_val     = commitVal_q;
    assign commit_rob_pos = commitPos_q;
    assign commit_store   = commitStore_q;
    assign rollback       = rollback_q;
    assign rollback_pc    = rollbackPc_q;

    // A retiring head frees its slot, so a full queue can still accept an issue that cycle.
    always_comb begin
        retireOk   = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
        mispredict = retireOk && isBr_q[head_q] && (jmp_q[head_q] != predJmp_q[head_q]);
        issueOk    = issue && (!rob_full || retireOk) && !mispredict;
        lsbWrite   = lsb_result && busy_q[lsb_rob_pos] &&
                     !(alu_result && (alu_rob_pos == lsb_rob_pos));
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retireOk) head_d = head_q + ROB_POS_W'(1);
            if (issueOk)  tail_d = tail_q + ROB_POS_W'(1);
            count_d = count_q + (ROB_POS_W+1)'(issueOk) - (ROB_POS_W+1)'(retireOk);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_q      <= 1'b0;
            commitStore_q <= 1'b0;
            rollback_q    <= 1'b0;
            commitRd_q    <= '0;
            commitVal_q   <= '0;
            commitPos_q   <= '0;
            rollbackPc_q  <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_q      <= retireOk;
            commitStore_q <= retireOk && isStore_q[head_q];
            rollback_q    <= mispredict;
            if (retireOk) begin
                commitRd_q  <= rd_q[head_q];
                commitVal_q <= val_q[head_q];
                commitPos_q <= head_q;
            end
            if (mispredict) begin
                rollbackPc_q <= pc_q[head_q];
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                if (alu_result && busy_q[alu_rob_pos]) begin
                    ready_q[alu_rob_pos] <= 1'b1;
                    val_q[alu_rob_pos]   <= alu_val;
                    jmp_q[alu_rob_pos]   <= alu_jmp;
                    pc_q[alu_rob_pos]    <= alu_pc;
                end
                if (lsbWrite) begin
                    ready_q[lsb_rob_pos] <= 1'b1;
                    if (!isStore_q[lsb_rob_pos]) val_q[lsb_rob_pos] <= lsb_val;
                end
                if (retireOk) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
                // Ordered last so a same-cycle issue into the freed head slot wins.
                if (issueOk) begin
                    busy_q[tail_q]    <= 1'b1;
                    ready_q[tail_q]   <= issue_ready;
                    rd_q[tail_q]      <= issue_rd;
                    val_q[tail_q]     <= issue_val;
                    isBr_q[tail_q]    <= issue_is_br;
                    isStore_q[tail_q] <= issue_is_store;
                    predJmp_q[tail_q] <= issue_pred_jmp;
                    jmp_q[tail_q]     <= 1'b0;
                    pc_q[tail_q]      <= '0;
                end
            end
        end
    end

    // Operand lookup forwards results that are on the buses this very cycle.
    always_comb begin
        q1_ready = busy_q[q1_pos] && ready_q[q1_pos];
        q1_val   = val_q[q1_pos];
        q2_ready = busy_q[q2_pos] && ready_q[q2_pos];
        q2_val   = val_q[q2_pos];
        if (lsb_result && lsb_rob_pos == q1_pos) begin
            q1_ready = 1'b1;
            q1_val   = lsb_val;
        end
        if (alu_result && alu_rob_pos == q1_pos) begin
            q1_ready = 1'b1;
            q1_val   = alu_val;
        end
        if (lsb_result && lsb_rob_pos == q2_pos) begin
            q2_ready = 1'b1;
            q2_val   = lsb_val;
        end
        if (alu_result && alu_rob_pos == q2_pos) begin
            q2_ready = 1'b1;
            q2_val   = alu_val;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table for commit ordering,
// plus hand sequences for fill/full, mispredict flush, bypass, freeze and reset.
module tb_reorder_buffer;

    logic        clk, rst, rdy;
    logic        rob_full, issue, issue_ready, issue_is_br, issue_is_store, issue_pred_jmp;
    logic [3:0]  issue_rob_pos, alu_rob_pos, lsb_rob_pos, q1_pos, q2_pos, commit_rob_pos;
    logic [4:0]  issue_rd, commit_rd;
    logic [31:0] issue_val, alu_val, alu_pc, lsb_val, q1_val, q2_val, commit_val, rollback_pc;
    logic        alu_result, alu_jmp, lsb_result, q1_ready, q2_ready;
    logic        commit, commit_store, rollback;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic        iss;   logic [4:0]  rd;  logic irdy; logic [31:0] ival;
        logic        br;    logic        pred; logic st;
        logic        alu;   logic [3:0]  apos; logic [31:0] aval; logic ajmp; logic [31:0] apc;
        logic        lsb;   logic [3:0]  lpos; logic [31:0] lval;
        logic        eCommit; logic [4:0] eRd; logic [31:0] eVal; logic [3:0] ePos;
        logic        eStore;  logic eRb; logic [3:0] eTail;
    } vec_t;

    vec_t vecs [22];

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_full(rob_full),
        .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_val(issue_val), .issue_is_br(issue_is_br),
        .issue_is_store(issue_is_store), .issue_pred_jmp(issue_pred_jmp),
        .alu_result(alu_result), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
        .alu_jmp(alu_jmp), .alu_pc(alu_pc),
        .lsb_result(lsb_result), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
        .q1_pos(q1_pos), .q2_pos(q2_pos), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos), .commit_store(commit_store),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        issue = 0; issue_rd = 0; issue_ready = 0; issue_val = 0;
        issue_is_br = 0; issue_is_store = 0; issue_pred_jmp = 0;
        alu_result = 0; alu_rob_pos = 0; alu_val = 0; alu_jmp = 0; alu_pc = 0;
        lsb_result = 0; lsb_rob_pos = 0; lsb_val = 0;
        q1_pos = 0; q2_pos = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        issue = v.iss; issue_rd = v.rd; issue_ready = v.irdy; issue_val = v.ival;
        issue_is_br = v.br; issue_pred_jmp = v.pred; issue_is_store = v.st;
        alu_result = v.alu; alu_rob_pos = v.apos; alu_val = v.aval;
        alu_jmp = v.ajmp; alu_pc = v.apc;
        lsb_result = v.lsb; lsb_rob_pos = v.lpos; lsb_val = v.lval;
    endtask

    task automatic doReset();
        rst = 1; rdy = 1;
        clearInputs();
        step();
        step();
        rst = 0;
    endtask

    initial begin
        vecs[0]  = '{iss:1, rd:5, eTail:1, default:'0};
        vecs[1]  = '{alu:1, apos:0, aval:32'h1234, eTail:1, default:'0};
        vecs[2]  = '{eCommit:1, eRd:5, eVal:32'h1234, ePos:0, eTail:1, default:'0};
        vecs[3]  = '{eTail:1, default:'0};
        vecs[4]  = '{iss:1, rd:6, eTail:2, default:'0};
        vecs[5]  = '{iss:1, rd:7, eTail:3, default:'0};
        vecs[6]  = '{alu:1, apos:2, aval:32'h22, eTail:3, default:'0};
        vecs[7]  = '{lsb:1, lpos:1, lval:32'h11, eTail:3, default:'0};
        vecs[8]  = '{eCommit:1, eRd:6, eVal:32'h11, ePos:1, eTail:3, default:'0};
        vecs[9]  = '{eCommit:1, eRd:7, eVal:32'h22, ePos:2, eTail:3, default:'0};
        vecs[10] = '{eTail:3, default:'0};
        vecs[11] = '{iss:1, rd:0, irdy:1, ival:32'h55, st:1, eTail:4, default:'0};
        vecs[12] = '{eCommit:1, eRd:0, eVal:32'h55, ePos:3, eStore:1, eTail:4, default:'0};
        vecs[13] = '{iss:1, rd:8, eTail:5, default:'0};
        vecs[14] = '{alu:1, apos:4, aval:32'hA, lsb:1, lpos:4, lval:32'hB, eTail:5, default:'0};
        vecs[15] = '{eCommit:1, eRd:8, eVal:32'hA, ePos:4, eTail:5, default:'0};
        vecs[16] = '{iss:1, rd:0, br:1, pred:1, eTail:6, default:'0};
        vecs[17] = '{alu:1, apos:5, aval:32'h4, ajmp:1, apc:32'h40, eTail:6, default:'0};
        vecs[18] = '{eCommit:1, eRd:0, eVal:32'h4, ePos:5, eTail:6, default:'0};
        vecs[19] = '{alu:1, apos:6, aval:32'h99, eTail:6, default:'0};
        vecs[20] = '{iss:1, rd:11, eTail:7, default:'0};
        vecs[21] = '{eTail:7, default:'0};

        // Reset values
        doReset();
        checkOutput("reset_commit", {31'd0, commit}, 0);
        checkOutput("reset_rollback", {31'd0, rollback}, 0);
        checkOutput("reset_full", {31'd0, rob_full}, 0);
        checkOutput("reset_tail", {28'd0, issue_rob_pos}, 0);
        checkOutput("reset_commit_val", commit_val, 0);
        checkOutput("reset_rollback_pc", rollback_pc, 0);

        // Table: in-order commit, out-of-order writeback, store, CDB priority, branches
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("v%0d_commit", i), {31'd0, commit}, {31'd0, vecs[i].eCommit});
            checkOutput($sformatf("v%0d_rollback", i), {31'd0, rollback}, {31'd0, vecs[i].eRb});
            checkOutput($sformatf("v%0d_tail", i), {28'd0, issue_rob_pos}, {28'd0, vecs[i].eTail});
            if (vecs[i].eCommit) begin
                checkOutput($sformatf("v%0d_rd", i), {27'd0, commit_rd}, {27'd0, vecs[i].eRd});
                checkOutput($sformatf("v%0d_val", i), commit_val, vecs[i].eVal);
                checkOutput($sformatf("v%0d_pos", i), {28'd0, commit_rob_pos}, {28'd0, vecs[i].ePos});
                checkOutput($sformatf("v%0d_store", i), {31'd0, commit_store}, {31'd0, vecs[i].eStore});
            end
        end
        clearInputs();

        // Fill to full, then an extra issue must be dropped
        doReset();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("fill%0d_tail", i), {28'd0, issue_rob_pos}, i);
            issue = 1; issue_rd = 5'd1; issue_ready = 0;
            step();
            checkOutput($sformatf("fill%0d_full", i), {31'd0, rob_full}, (i == 15) ? 1 : 0);
        end
        step();
        checkOutput("over_full", {31'd0, rob_full}, 1);
        checkOutput("over_tail", {28'd0, issue_rob_pos}, 0);

        // Full queue: head retires while a new issue takes its slot
        issue = 0; alu_result = 1; alu_rob_pos = 0; alu_val = 32'h5;
        step();
        checkOutput("fullret_pre_commit", {31'd0, commit}, 0);
        alu_result = 0; issue = 1; issue_rd = 5'd3;
        step();
        issue = 0; q1_pos = 0;
        checkOutput("fullret_commit", {31'd0, commit}, 1);
        checkOutput("fullret_val", commit_val, 32'h5);
        checkOutput("fullret_pos", {28'd0, commit_rob_pos}, 0);
        checkOutput("fullret_full", {31'd0, rob_full}, 1);
        checkOutput("fullret_tail", {28'd0, issue_rob_pos}, 1);
        #1;
        checkOutput("fullret_slot0_notready", {31'd0, q1_ready}, 0);
        step();
        checkOutput("fullret_after_commit", {31'd0, commit}, 0);
        checkOutput("fullret_after_full", {31'd0, rob_full}, 1);
        clearInputs();

        // Mispredict flush; issue and writeback in the flush cycle are dropped
        doReset();
        issue = 1; issue_rd = 0; issue_is_br = 1; issue_pred_jmp = 0;
        step();
        issue_is_br = 0; issue_rd = 5'd4;
        step();
        issue = 0; alu_result = 1; alu_rob_pos = 0; alu_jmp = 1; alu_pc = 32'h80;
        step();
        checkOutput("mp_pre_rollback", {31'd0, rollback}, 0);
        alu_result = 0; issue = 1; issue_rd = 5'd9;
        lsb_result = 1; lsb_rob_pos = 1; lsb_val = 32'h77;
        step();
        clearInputs();
        q1_pos = 1;
        checkOutput("mp_rollback", {31'd0, rollback}, 1);
        checkOutput("mp_rollback_pc", rollback_pc, 32'h80);
        checkOutput("mp_commit", {31'd0, commit}, 1);
        checkOutput("mp_commit_pos", {28'd0, commit_rob_pos}, 0);
        checkOutput("mp_tail", {28'd0, issue_rob_pos}, 0);
        checkOutput("mp_full", {31'd0, rob_full}, 0);
        step();
        checkOutput("mp_after_rollback", {31'd0, rollback}, 0);
        checkOutput("mp_after_commit", {31'd0, commit}, 0);
        checkOutput("mp_after_tail", {28'd0, issue_rob_pos}, 0);
        checkOutput("mp_slot1_cleared", {31'd0, q1_ready}, 0);

        // Same-cycle operand bypass, ALU priority over LSB
        q1_pos = 3; q2_pos = 3;
        alu_result = 1; alu_rob_pos = 3; alu_val = 32'h7;
        lsb_result = 1; lsb_rob_pos = 3; lsb_val = 32'h8;
        #1;
        checkOutput("byp_q1_ready", {31'd0, q1_ready}, 1);
        checkOutput("byp_q1_val", q1_val, 32'h7);
        checkOutput("byp_q2_val_alu_prio", q2_val, 32'h7);
        alu_result = 0; q2_pos = 6; lsb_rob_pos = 6; lsb_val = 32'h9;
        #1;
        checkOutput("byp_q1_idle", {31'd0, q1_ready}, 0);
        checkOutput("byp_q2_lsb_ready", {31'd0, q2_ready}, 1);
        checkOutput("byp_q2_lsb_val", q2_val, 32'h9);
        clearInputs();

        // rdy=0 freezes state and registered outputs
        issue = 1; issue_rd = 5'd10;
        step();
        rdy = 0; issue_rd = 5'd12; alu_result = 1; alu_rob_pos = 0; alu_val = 32'h33;
        step();
        checkOutput("frz_tail", {28'd0, issue_rob_pos}, 1);
        rdy = 1; clearInputs();
        step();
        checkOutput("frz_no_commit", {31'd0, commit}, 0);
        alu_result = 1; alu_rob_pos = 0; alu_val = 32'h44;
        step();
        clearInputs();
        step();
        checkOutput("frz_commit", {31'd0, commit}, 1);
        checkOutput("frz_commit_val", commit_val, 32'h44);
        checkOutput("frz_commit_rd", {27'd0, commit_rd}, 10);
        rdy = 0;
        step();
        checkOutput("frz_commit_hold", {31'd0, commit}, 1);
        rdy = 1;
        step();
        checkOutput("frz_commit_drop", {31'd0, commit}, 0);

        // Reset overrides a pending mispredict
        issue = 1; issue_rd = 0; issue_is_br = 1; issue_pred_jmp = 1;
        step();
        clearInputs();
        alu_result = 1; alu_rob_pos = 1; alu_jmp = 0; alu_pc = 32'h200;
        step();
        clearInputs();
        rst = 1;
        step();
        rst = 0;
        checkOutput("rst_rollback", {31'd0, rollback}, 0);
        checkOutput("rst_commit", {31'd0, commit}, 0);
        checkOutput("rst_tail", {28'd0, issue_rob_pos}, 0);
        checkOutput("rst_rollback_pc", rollback_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
